// File: rtl/uart_cmd_bridge_if.sv
// Signal bundle between uart_cmd_bridge and its surroundings: the uart
// RX/TX FIFO handshakes and the byte-wide register bus.
// master: the bridge side.  slave: FIFOs + register bus side.
interface uart_cmd_bridge_if;
    logic       rx_empty;
    logic [7:0] r_data;
    logic       rd_uart;
    logic       tx_full;
    logic [7:0] w_data;
    logic       wr_uart;
    logic [7:0] bus_addr;
    logic [7:0] bus_wdata;
    logic       bus_we;
    logic       bus_re;
    logic [7:0] bus_rdata;

    modport master (
        input  rx_empty, r_data, tx_full, bus_rdata,
        output rd_uart, w_data, wr_uart, bus_addr, bus_wdata, bus_we, bus_re
    );

    modport slave (
        output rx_empty, r_data, tx_full, bus_rdata,
        input  rd_uart, w_data, wr_uart, bus_addr, bus_wdata, bus_we, bus_re
    );
endinterface

// File: rtl/uart_cmd_bridge.sv
// uart_cmd_bridge: pops command frames from the uart RX FIFO, performs one
// register-bus access per frame and pushes a single response byte to TX.
//   'W' addr data -> write, response 'K'
//   'R' addr      -> read,  response is the read byte
//   other opcode  -> response '?'
// Optional build macro UART_CMD_TIMEOUT_EN: adds an inter-byte timeout that
// abandons a partial frame and pulses to_err; otherwise to_err is tied low.
module uart_cmd_bridge #(
    parameter logic [7:0]  CMD_WR    = 8'h57,
    parameter logic [7:0]  CMD_RD    = 8'h52,
    parameter logic [7:0]  RSP_ACK   = 8'h4B,
    parameter logic [7:0]  RSP_ERR   = 8'h3F,
    parameter int unsigned TO_CYCLES = 50000000,
    parameter int unsigned TO_BIT    = 26
) (
    input  logic                  clk,
    input  logic                  reset,
    uart_cmd_bridge_if.master     link,
    output logic                  busy,
    output logic                  to_err
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_GET_ADDR = 3'd1;
    localparam logic [2:0] S_GET_DATA = 3'd2;
    localparam logic [2:0] S_BUS_WR   = 3'd3;
    localparam logic [2:0] S_BUS_RD   = 3'd4;
    localparam logic [2:0] S_RD_WAIT  = 3'd5;
    localparam logic [2:0] S_SEND     = 3'd6;

    // The timeout counter must be able to hold TO_CYCLES-1.
    if (TO_CYCLES < 2 || 64'(TO_CYCLES) > (64'd1 << TO_BIT)) begin : g_bad_timeout
        $error("uart_cmd_bridge: TO_CYCLES does not fit in TO_BIT bits");
    end

    logic [2:0] state;
    logic       is_wr;
    logic [7:0] w_data_q;
    logic [7:0] addr_q;
    logic [7:0] wdata_q;
    logic       accepting;
    logic       waiting;
    logic       pop;
    logic       to_hit;

    assign accepting = (state == S_IDLE) || (state == S_GET_ADDR) || (state == S_GET_DATA);
    assign waiting   = (state == S_GET_ADDR) || (state == S_GET_DATA);
    assign pop       = accepting && !link.rx_empty && !reset;

    // Strobes are decoded from state so they are exactly one cycle wide;
    // reset masks them so nothing leaks out during the reset cycle.
    assign link.rd_uart   = pop;
    assign link.bus_we    = (state == S_BUS_WR) && !reset;
    assign link.bus_re    = (state == S_BUS_RD) && !reset;
    assign link.wr_uart   = (state == S_SEND) && !link.tx_full && !reset;
    assign link.w_data    = w_data_q;
    assign link.bus_addr  = addr_q;
    assign link.bus_wdata = wdata_q;
    assign busy           = (state != S_IDLE) && !reset;

`ifdef UART_CMD_TIMEOUT_EN
    logic [TO_BIT-1:0] to_cnt;
    logic              to_err_q;

    // Abort on the edge where the counter steps onto TO_CYCLES-1, so to_err
    // appears exactly TO_CYCLES cycles after the last pop.
    assign to_hit = waiting && link.rx_empty && (to_cnt == TO_BIT'(TO_CYCLES - 32'd2));
    assign to_err = to_err_q;

    // Inter-byte idle counter; any pop (including the opcode pop that enters
    // GET_ADDR) restarts it.
    always_ff @(posedge clk) begin
        if (reset) begin
            to_cnt   <= '0;
            to_err_q <= 1'b0;
        end else begin
            to_err_q <= to_hit;
            if (pop || !waiting) begin
                to_cnt <= '0;
            end else if (link.rx_empty) begin
                to_cnt <= to_cnt + 1'b1;
            end
        end
    end
`else
    assign to_hit = 1'b0;
    assign to_err = 1'b0;
`endif

    // Frame decode / bus access / response FSM.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            is_wr    <= 1'b0;
            w_data_q <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        if (link.r_data == CMD_WR || link.r_data == CMD_RD) begin
                            is_wr <= (link.r_data == CMD_WR);
                            state <= S_GET_ADDR;
                        end else begin
                            w_data_q <= RSP_ERR;
                            state    <= S_SEND;
                        end
                    end
                end
                S_GET_ADDR: begin
                    if (pop) begin
                        addr_q <= link.r_data;
                        state  <= is_wr ? S_GET_DATA : S_BUS_RD;
                    end else if (to_hit) begin
                        state <= S_IDLE;
                    end
                end
                S_GET_DATA: begin
                    if (pop) begin
                        wdata_q <= link.r_data;
                        state   <= S_BUS_WR;
                    end else if (to_hit) begin
                        state <= S_IDLE;
                    end
                end
                S_BUS_WR: begin
                    w_data_q <= RSP_ACK;
                    state    <= S_SEND;
                end
                S_BUS_RD: begin
                    state <= S_RD_WAIT;
                end
                S_RD_WAIT: begin
                    w_data_q <= link.bus_rdata;
                    state    <= S_SEND;
                end
                S_SEND: begin
                    if (!link.tx_full) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/uart_cmd_bridge.md
Name: uart_cmd_bridge

Overview:
Host-side responder sitting on the FIFO side of the uart block. It pops command bytes from the uart RX FIFO, decodes a 2- or 3-byte register-access protocol, performs one access on a simple byte-wide register bus, and pushes a 1-byte response into the uart TX FIFO. It gives the PC (the initiator) read/write access to on-chip registers over the serial link.

Parameters:
CMD_WR, 8'h57, opcode for a write ('W'); frame is CMD_WR, addr, data; response is RSP_ACK
CMD_RD, 8'h52, opcode for a read ('R'); frame is CMD_RD, addr; response is the read data byte
RSP_ACK, 8'h4B, write acknowledge byte ('K')
RSP_ERR, 8'h3F, unknown-opcode response byte ('?')
TO_CYCLES, 50000000, inter-byte timeout in clk cycles; used only with UART_CMD_TIMEOUT_EN
TO_BIT, 26, width of the timeout counter

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
rx_empty  in  1  RX FIFO empty; r_data is valid when low
r_data  in  8  RX FIFO head byte
rd_uart  out  1  RX FIFO pop strobe, 1 cycle
tx_full  in  1  TX FIFO full
w_data  out  8  TX FIFO write byte
wr_uart  out  1  TX FIFO push strobe, 1 cycle
bus_addr  out  8  register address
bus_wdata  out  8  register write data
bus_we  out  1  write strobe, 1 cycle
bus_re  out  1  read strobe, 1 cycle
bus_rdata  in  8  read data, valid exactly 1 cycle after bus_re
busy  out  1  high in every state except IDLE
to_err  out  1  1-cycle pulse on timeout abort; held 0 when the feature is off

Behaviour:
- Reset: the FSM goes to IDLE. rd_uart, wr_uart, bus_we, bus_re, busy and to_err are 0. w_data, bus_addr and bus_wdata are 8'h00. A reset mid-frame discards any partial frame without a response.
- A byte is consumed in a cycle when rx_empty=0 in an accepting state: rd_uart=1 in that cycle, and r_data is captured at the same edge. At most one pop per cycle.
- States:
  - IDLE: on a byte, if it equals CMD_WR or CMD_RD, latch the opcode and go to GET_ADDR. Otherwise load w_data=RSP_ERR and go to SEND.
  - GET_ADDR: on a byte, latch bus_addr. If the opcode is WR, go to GET_DATA; if RD, go to BUS_RD.
  - GET_DATA: on a byte, latch bus_wdata and go to BUS_WR.
  - BUS_WR: bus_we=1 for 1 cycle; w_data<=RSP_ACK; go to SEND.
  - BUS_RD: bus_re=1 for 1 cycle; go to RD_WAIT.
  - RD_WAIT: w_data<=bus_rdata; go to SEND.
  - SEND: when tx_full=0, wr_uart=1 for 1 cycle and go to IDLE. While tx_full=1, stay in SEND with w_data stable, and pop no RX bytes.
- Latency, counted from the pop of the final frame byte with the TX FIFO not full:
  - Write: bus_we 1 cycle later, wr_uart 2 cycles later.
  - Read: bus_re 1 cycle later, wr_uart 3 cycles later.
  - Bad opcode: wr_uart 1 cycle later.
- Exactly one response byte per frame. RX bytes arriving during BUS_*, RD_WAIT or SEND remain in the FIFO and are not lost.
- bus_addr and bus_wdata hold their last values between accesses.
- Back-to-back frames already queued in the RX FIFO are processed with no idle gap beyond the IDLE cycle.
- Address 8'hFF and data 8'h00 or 8'hFF are legal and carry no special meaning. Opcode bytes are legal as addr or data.

Optional Feature:
UART_CMD_TIMEOUT_EN
- Defined: a TO_BIT-wide counter clears on every pop and on entry to GET_ADDR. It increments each cycle spent in GET_ADDR or GET_DATA with rx_empty=1. When it reaches TO_CYCLES-1, the FSM returns to IDLE, drops the partial frame, sends no response, and pulses to_err for 1 cycle.
- Undefined: no counter is built, to_err is tied to 0, and partial frames wait indefinitely.

Test Plan:
1. Write then read back. Queue 57 10 A5; bus_we=1 with bus_addr=10, bus_wdata=A5 exactly once; TX receives 4B. Then queue 52 10 with a model returning A5; bus_re pulses once with addr 10; TX receives A5 3 cycles after the pop of 10.
2. Bad opcode. Queue 00, then FF; TX receives 3F, 3F; no bus strobes.
3. Back-to-back frames. Queue 52 01 52 02 57 03 5A in the FIFO at once; TX order is rd(01), rd(02), 4B; bus accesses happen in frame order.
4. TX backpressure. Hold tx_full=1 for 100 cycles after 52 20; FSM stays in SEND, no rd_uart, w_data stable; the byte is pushed on the first cycle tx_full=0.
5. Reset mid-frame. Pop 57 40, assert reset for 1 cycle, then queue 52 40; outputs show reset values, no bus_we occurs, and only the read response is sent.
6. Timeout, with UART_CMD_TIMEOUT_EN and TO_CYCLES=100. Send 57 only; to_err pulses 100 cycles after the pop with no TX byte; a following 52 07 is handled normally.
